// File: rtl/lbp_host_pkg.sv
// Shared sizing, state encoding and image-border helpers for the LBP host.
package lbp_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int NPIX   = 16384;

  localparam logic [6:0] BORDER_LO = 7'd0;
  localparam logic [6:0] BORDER_HI = 7'd127;

  typedef enum logic [2:0] {IDLE, LOAD, SERVE, DUMP, DONE} state_t;

  // Address is {row[13:7], col[6:0]}; true on the outermost ring of the image.
  function automatic logic is_border(input logic [ADDR_W-1:0] addr);
    logic [6:0] row;
    logic [6:0] col;
    row = addr[ADDR_W-1:7];
    col = addr[6:0];
    return (row == BORDER_LO) || (row == BORDER_HI) ||
           (col == BORDER_LO) || (col == BORDER_HI);
  endfunction
endpackage

// File: rtl/lbp_host_if.sv
// Bundle of the load, pixel-service, result-write and dump streams around lbp_host.
// Handshakes: a beat transfers on a rising edge where both valid and ready are 1;
// the sender holds valid and payload stable until that edge.
interface lbp_host_if;
  import lbp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              done;
  logic              err;
  state_t            fsm_state;

  modport slave (
    input  in_valid, in_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, out_ready,
    output in_ready, gray_ready, gray_data, out_valid, out_addr, out_data, done, err,
           fsm_state
  );

  modport master (
    output in_valid, in_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, out_ready,
    input  in_ready, gray_ready, gray_data, out_valid, out_addr, out_data, done, err,
           fsm_state
  );
endinterface

// File: rtl/lbp_host_ram.sv
// NPIX x DATA_W storage: synchronous write port, asynchronous read port.
module lbp_host_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int NPIX   = 16384
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NPIX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lbp_host.sv
// Image host for an LBP engine: load gray image, serve pixels, collect results, dump.
// Optional macro LBP_HOST_BORDER_CHECK_EN drops and flags result writes on the image border.
module lbp_host #(
  parameter int ADDR_W = lbp_pkg::ADDR_W,
  parameter int DATA_W = lbp_pkg::DATA_W,
  parameter int NPIX   = lbp_pkg::NPIX
) (
  input  logic       clk,
  input  logic       reset,
  lbp_host_if.slave  bus
);
  import lbp_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

  state_t            state;
  logic [ADDR_W-1:0] load_idx;
  logic [ADDR_W-1:0] dump_idx;
  logic              in_ready_q;
  logic              gray_ready_q;
  logic              out_valid_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              lbp_drop;
  logic              lbp_we;
  logic              misuse;
  logic              res_we;
  logic [ADDR_W-1:0] res_waddr;
  logic [DATA_W-1:0] res_wdata;
  logic [DATA_W-1:0] gray_rd;
  logic [DATA_W-1:0] res_rd;

  assign accept = (state == LOAD) && bus.in_valid && in_ready_q;

`ifdef LBP_HOST_BORDER_CHECK_EN
  assign lbp_drop = is_border(bus.lbp_addr);
`else
  assign lbp_drop = 1'b0;
`endif

  assign lbp_we = (state == SERVE) && bus.lbp_valid && !lbp_drop;
  assign misuse = (state != SERVE) && (bus.lbp_valid || bus.gray_req || bus.finish);

  // Loading clears the result image so unwritten addresses dump as zero.
  assign res_we    = accept || lbp_we;
  assign res_waddr = accept ? load_idx : bus.lbp_addr;
  assign res_wdata = accept ? '0 : bus.lbp_data;

  lbp_host_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) u_gray (
    .clk   (clk),
    .we    (accept),
    .waddr (load_idx),
    .wdata (bus.in_data),
    .raddr (bus.gray_addr),
    .rdata (gray_rd)
  );

  lbp_host_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) u_result (
    .clk   (clk),
    .we    (res_we),
    .waddr (res_waddr),
    .wdata (res_wdata),
    .raddr (dump_idx),
    .rdata (res_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      load_idx     <= '0;
      dump_idx     <= '0;
      in_ready_q   <= 1'b0;
      gray_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (misuse || ((state == SERVE) && bus.lbp_valid && lbp_drop)) err_q <= 1'b1;
      case (state)
        IDLE: begin
          state      <= LOAD;
          load_idx   <= '0;
          in_ready_q <= 1'b1;
        end
        LOAD: begin
          if (accept) begin
            if (load_idx == LAST_IDX) begin
              state        <= SERVE;
              load_idx     <= '0;
              in_ready_q   <= 1'b0;
              gray_ready_q <= 1'b1;
            end else begin
              load_idx <= load_idx + 1'b1;
            end
          end
        end
        SERVE: begin
          if (bus.finish) begin
            state        <= DUMP;
            gray_ready_q <= 1'b0;
            out_valid_q  <= 1'b1;
            dump_idx     <= '0;
          end
        end
        DUMP: begin
          if (bus.out_ready) begin
            if (dump_idx == LAST_IDX) begin
              state       <= DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.gray_ready = gray_ready_q;
  assign bus.gray_data  = ((state == SERVE) && bus.gray_req) ? gray_rd : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = dump_idx;
  assign bus.out_data   = out_valid_q ? res_rd : '0;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_lbp_host.sv
// Directed bench for lbp_host: ramp load, pixel reads, result writes, stalled dump, reset abort.
module tb_lbp_host;
  import lbp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lbp_host_if bus ();

  lbp_host dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        req;
    logic [13:0] addr;
    logic [7:0]  exp_data;
  } gvec_t;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } wvec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_res [NPIX];
  logic [7:0] exp_q [$];
  logic       exp_err;
  gvec_t      gv [7];
  wvec_t      wv [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    bus.finish    = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  function automatic logic tb_border(input logic [13:0] a);
    return (a[13:7] == 7'd0) || (a[13:7] == 7'd127) || (a[6:0] == 7'd0) || (a[6:0] == 7'd127);
  endfunction

  task automatic model_write(input logic [13:0] a, input logic [7:0] d);
`ifdef LBP_HOST_BORDER_CHECK_EN
    if (tb_border(a)) exp_err = 1'b1;
    else exp_res[a] = d;
`else
    if (tb_border(a)) exp_res[a] = d;
    else exp_res[a] = d;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    check({tag, "_gray_ready"}, 32'(bus.gray_ready), 32'd0);
    check({tag, "_gray_data"},  32'(bus.gray_data),  32'd0);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, "_out_addr"},   32'(bus.out_addr),   32'd0);
    check({tag, "_out_data"},   32'(bus.out_data),   32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
    check({tag, "_err"},        32'(bus.err),        32'd0);
    check({tag, "_state"},      32'(bus.fsm_state),  32'(IDLE));
  endtask

  task automatic load_ramp();
    bit ok;
    for (int i = 0; i < NPIX; i++) begin
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      if (i == NPIX - 1) check("gray_ready_before_last_beat", 32'(bus.gray_ready), 32'd0);
      for (int t = 0; t < 8; t++) begin
        ok = bus.in_ready;
        tick();
        if (ok) break;
      end
      if (!ok) begin
        check("load_beat_accepted", 32'd0, 32'd1);
        break;
      end
    end
    bus.in_valid = 1'b0;
    for (int a = 0; a < NPIX; a++) exp_res[a] = 8'h00;
    check("gray_ready_after_load", 32'(bus.gray_ready), 32'd1);
    check("in_ready_after_load",   32'(bus.in_ready),   32'd0);
    check("state_serve",           32'(bus.fsm_state),  32'(SERVE));
  endtask

  // Returns early (without accepting) when out_addr reaches stop_at.
  task automatic dump(input int stop_at, input bit do_stall);
    bit seen;
    exp_q.delete();
    for (int a = 0; a < NPIX; a++) exp_q.push_back(exp_res[a]);
    bus.out_ready = 1'b1;
    for (int b = 0; b < NPIX; b++) begin
      seen = 1'b0;
      for (int t = 0; t < 8; t++) begin
        if (bus.out_valid) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      if (!seen) begin
        check("dump_out_valid", 32'd0, 32'd1);
        return;
      end
      if (b == stop_at) return;
      check("dump_addr", 32'(bus.out_addr), 32'(b));
      check("dump_data", 32'(bus.out_data), 32'(exp_q[0]));
      if (do_stall && b == 'h10) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_addr",  32'(bus.out_addr),  32'h10);
          check("stall_data",  32'(bus.out_data),  32'(exp_q[0]));
        end
        bus.out_ready = 1'b1;
      end
      tick();
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    gv[0] = '{1'b1, 14'h0081, 8'h81};
    gv[1] = '{1'b1, 14'h0000, 8'h00};
    gv[2] = '{1'b1, 14'h3FFF, 8'hFF};
    gv[3] = '{1'b0, 14'h0081, 8'h00};
    gv[4] = '{1'b1, 14'h0100, 8'h00};
    gv[5] = '{1'b1, 14'h00FE, 8'hFE};
    gv[6] = '{1'b1, 14'h1234, 8'h34};
    wv[0] = '{14'h0081, 8'hA5};
    wv[1] = '{14'h0305, 8'h11};
    wv[2] = '{14'h0305, 8'h22};
    wv[3] = '{14'h007F, 8'hFF};
    wv[4] = '{14'h3FFF, 8'h77};
    wv[5] = '{14'h2040, 8'h5A};
    exp_err = 1'b0;

    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    check_reset_outputs("rst0");
    reset = 1'b1;
    tick();
    check("enter_load_state", 32'(bus.fsm_state), 32'(LOAD));
    check("enter_load_ready", 32'(bus.in_ready),  32'd1);

    load_ramp();

    for (int k = 0; k < 7; k++) begin
      bus.gray_req  = gv[k].req;
      bus.gray_addr = gv[k].addr;
      #1;
      check($sformatf("gray_read_%0d", k), 32'(bus.gray_data), 32'(gv[k].exp_data));
      tick();
    end
    bus.gray_req = 1'b0;

    bus.in_valid = 1'b1;
    #1;
    check("in_ready_in_serve", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_valid = 1'b0;

    bus.lbp_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.lbp_addr = wv[k].addr;
      bus.lbp_data = wv[k].data;
      model_write(wv[k].addr, wv[k].data);
      tick();
    end
    bus.lbp_addr = 14'h0102;
    bus.lbp_data = 8'h3C;
    bus.finish   = 1'b1;
    model_write(14'h0102, 8'h3C);
    tick();
    idle_inputs();
    check("state_dump",        32'(bus.fsm_state), 32'(DUMP));
    check("err_after_writes",  32'(bus.err),       32'(exp_err));

    dump(-1, 1'b1);
    check("done_after_dump",      32'(bus.done),      32'd1);
    check("out_valid_after_dump", 32'(bus.out_valid), 32'd0);
    check("state_done",           32'(bus.fsm_state), 32'(DONE));

    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h0081;
    #1;
    check("gray_data_outside_serve", 32'(bus.gray_data), 32'd0);
    tick();
    bus.gray_req = 1'b0;
    check("err_misuse_sticky", 32'(bus.err), 32'd1);
    check("done_held",         32'(bus.done), 32'd1);

    reset = 1'b0;
    #1;
    check_reset_outputs("rst1");
    tick();
    reset = 1'b1;
    tick();
    check("reload_state", 32'(bus.fsm_state), 32'(LOAD));

    load_ramp();
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0081;
    bus.lbp_data  = 8'hA5;
    model_write(14'h0081, 8'hA5);
    tick();
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b1;
    tick();
    bus.finish = 1'b0;
    check("run2_state_dump", 32'(bus.fsm_state), 32'(DUMP));

    dump('h200, 1'b0);
    check("abort_point_addr", 32'(bus.out_addr), 32'h200);
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_done",      32'(bus.done),      32'd0);
    check("abort_out_addr",  32'(bus.out_addr),  32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("after_abort_state",    32'(bus.fsm_state), 32'(LOAD));
    check("after_abort_in_ready", 32'(bus.in_ready),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lbp_host.md
LBP_HOST -- requirements
Module: lbp_host

Interface
REQ-001 SHALL have parameter ADDR_W, 14, pixel address width (row[13:7], col[6:0]).
REQ-002 SHALL have parameter DATA_W, 8, gray/LBP pixel width.
REQ-003 SHALL have parameter NPIX, 16384, image pixel count (2**ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_W: raster-order image load stream.
REQ-007 SHALL have ports gray_ready output 1, gray_req input 1, gray_addr input ADDR_W, gray_data output DATA_W: pixel read service to the LBP engine.
REQ-008 SHALL have ports lbp_valid input 1, lbp_addr input ADDR_W, lbp_data input DATA_W, finish input 1: result write sink.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_addr output ADDR_W, out_data output DATA_W: result dump stream.
REQ-010 SHALL have ports done output 1 (dump complete) and err output 1 (sticky protocol error).

Function
REQ-011 SHALL implement states IDLE, LOAD, SERVE, DUMP, DONE.
REQ-012 IDLE SHALL go to LOAD on the first cycle after reset release; load index cleared to 0.
REQ-013 LOAD: in_ready=1; on in_valid&in_ready, gray mem[idx]<=in_data, result mem[idx]<=0, idx++; after idx NPIX-1 accepted -> SERVE.
REQ-014 SERVE: gray_ready=1 every cycle; gray_data SHALL equal gray mem[gray_addr] combinationally while gray_req=1 (zero-cycle latency), else 0.
REQ-015 SERVE: lbp_valid=1 at a rising edge SHALL write result mem[lbp_addr]<=lbp_data; back-to-back writes every cycle supported; later write to same address overwrites.
REQ-016 SERVE: finish=1 at an edge SHALL go to DUMP; lbp_valid and finish in same cycle: write performed, then DUMP.
REQ-017 lbp_valid, gray_req, finish outside SERVE SHALL be ignored (no memory change), and SHALL set err.
REQ-018 DUMP: out_valid=1, out_addr from 0 upward, out_data=result mem[out_addr] combinationally; out_addr/out_data held stable while out_ready=0; advance on out_valid&out_ready.
REQ-019 After address NPIX-1 accepted SHALL go to DONE: out_valid=0, done=1, held until reset.
REQ-020 in_valid outside LOAD SHALL be ignored (in_ready=0), no err.
REQ-021 All counters ADDR_W wide; load/dump index wraps only via state exit, never re-enters 0 within a state.

Reset
REQ-022 On reset low, immediately: state=IDLE, in_ready=0, gray_ready=0, gray_data=0, out_valid=0, out_addr=0, out_data=0, done=0, err=0, indices=0.
REQ-023 Reset mid-operation SHALL abort the current phase; memory contents are don't-care and are rewritten by the next LOAD.

Configuration
REQ-024 Macro LBP_HOST_BORDER_CHECK_EN: defined -> SERVE writes with lbp_addr row or col equal to 0 or 127 SHALL be dropped (result stays 0) and set err; undefined -> such writes SHALL be stored normally and never set err.

Structure
REQ-025 Package lbp_pkg SHALL hold ADDR_W, DATA_W, NPIX, the state enum type, and border row/col constants 0 and 127.
REQ-026 Sub-module lbp_host_ram SHALL implement one NPIX x DATA_W memory with one synchronous write port and one asynchronous read port; instantiated twice (gray, result).

Verification
REQ-027 Load ramp pixel[i]=i[7:0], then gray_req with gray_addr=0x0081 -> gray_data=0x81 same cycle; gray_ready=1 only after 16384th load beat.
REQ-028 In SERVE write lbp_addr=0x0081 data 0xA5, finish next cycle -> DUMP beat at out_addr 0x0081 gives 0xA5, all unwritten addresses give 0x00, done=1 after beat 16383.
REQ-029 Drop out_ready low for 5 cycles at out_addr 0x0010 -> out_addr/out_data/out_valid unchanged, no beat skipped or duplicated.
REQ-030 lbp_valid with finish same cycle at addr 0x0102 data 0x3C -> value 0x3C dumped at 0x0102.
REQ-031 With LBP_HOST_BORDER_CHECK_EN, write addr 0x007F data 0xFF -> dumped 0x00, err=1; without macro -> dumped 0xFF, err=0.
REQ-032 Assert reset low mid-DUMP at out_addr 0x0200 -> out_valid=0, done=0 immediately; after release block reenters LOAD with in_ready=1.
